// File: rtl/operand_input_conditioner.sv
// Synchronises and debounces 8 toggle switches and 4 push buttons, then registers
// the (switch[3:0], buttons) operand pair for the downstream multiplier.
module operand_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned CNT_W           = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] toggle_switch,
  input  logic [3:0] push_button,
  output logic [7:0] sw_clean,
  output logic [3:0] pb_clean,
  output logic [3:0] pb_press,
  output logic [3:0] pb_release,
  output logic [3:0] operand_a,
  output logic [3:0] operand_b,
  output logic       operand_valid
);

  localparam int NBits = 12;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NBits-1:0] raw;
  logic [NBits-1:0] s1_q, s2_q;
  logic [NBits-1:0] clean_q, clean_d;
  logic [CNT_W-1:0] cnt_q [NBits];
  logic [CNT_W-1:0] cnt_d [NBits];
  logic [3:0]       press_q, release_q;
  logic [3:0]       op_a_q, op_b_q;
  logic             valid_q;
  logic [7:0]       op_cur;

  // Buttons occupy the top nibble so pb_clean is clean_q[11:8].
  assign raw = {push_button, toggle_switch};

  always_comb begin
    clean_d = clean_q;
    for (int i = 0; i < NBits; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          clean_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign op_cur = {clean_q[11:8], clean_q[3:0]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < NBits; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      clean_q   <= clean_d;
      // Pulses are registered alongside the clean update so they coincide with it.
      press_q   <= clean_d[11:8] & ~clean_q[11:8];
      release_q <= ~clean_d[11:8] & clean_q[11:8];
      for (int i = 0; i < NBits; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (op_cur != {op_b_q, op_a_q}) begin
        op_a_q  <= clean_q[3:0];
        op_b_q  <= clean_q[11:8];
        valid_q <= 1'b1;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign sw_clean      = clean_q[7:0];
  assign pb_clean      = clean_q[11:8];
  assign pb_press      = press_q;
  assign pb_release    = release_q;
  assign operand_a     = op_a_q;
  assign operand_b     = op_b_q;
  assign operand_valid = valid_q;

endmodule

// File: tb/tb_operand_input_conditioner.sv
// Directed bench for operand_input_conditioner built with a 4-cycle debounce.
module tb_operand_input_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] toggle_switch = 8'h00;
  logic [3:0] push_button = 4'h0;
  logic [7:0] sw_clean;
  logic [3:0] pb_clean, pb_press, pb_release, operand_a, operand_b;
  logic       operand_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  operand_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .toggle_switch(toggle_switch),
    .push_button  (push_button),
    .sw_clean     (sw_clean),
    .pb_clean     (pb_clean),
    .pb_press     (pb_press),
    .pb_release   (pb_release),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .operand_valid(operand_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_sw"}, 32'(sw_clean), 32'h0);
    check_eq({tag, "_pb"}, 32'(pb_clean), 32'h0);
    check_eq({tag, "_press"}, 32'(pb_press), 32'h0);
    check_eq({tag, "_rel"}, 32'(pb_release), 32'h0);
    check_eq({tag, "_opa"}, 32'(operand_a), 32'h0);
    check_eq({tag, "_opb"}, 32'(operand_b), 32'h0);
    check_eq({tag, "_valid"}, 32'(operand_valid), 32'h0);
  endtask

  initial begin
    // 1: inputs high through reset, re-qualified after release
    toggle_switch = 8'hFF;
    push_button   = 4'hF;
    tick(3);
    check_all_zero("rst");
    reset = 1'b0;
    tick(5);
    check_eq("t1_pb_early", 32'(pb_clean), 32'h0);
    check_eq("t1_sw_early", 32'(sw_clean), 32'h0);
    tick(1);
    check_eq("t1_pb", 32'(pb_clean), 32'hF);
    check_eq("t1_sw", 32'(sw_clean), 32'hFF);
    check_eq("t1_press", 32'(pb_press), 32'hF);
    check_eq("t1_valid_early", 32'(operand_valid), 32'h0);
    tick(1);
    check_eq("t1_press_gone", 32'(pb_press), 32'h0);
    check_eq("t1_opa", 32'(operand_a), 32'hF);
    check_eq("t1_opb", 32'(operand_b), 32'hF);
    check_eq("t1_valid", 32'(operand_valid), 32'h1);
    tick(1);
    check_eq("t1_valid_gone", 32'(operand_valid), 32'h0);

    // return everything to 0
    toggle_switch = 8'h00;
    push_button   = 4'h0;
    tick(6);
    check_eq("t1z_rel", 32'(pb_release), 32'hF);
    check_eq("t1z_pb", 32'(pb_clean), 32'h0);
    tick(1);
    check_eq("t1z_valid", 32'(operand_valid), 32'h1);
    check_eq("t1z_opa", 32'(operand_a), 32'h0);
    check_eq("t1z_opb", 32'(operand_b), 32'h0);
    tick(2);

    // 2: 3-cycle pulse on button 0 is rejected
    for (int c = 0; c < 11; c++) begin
      push_button = (c < 3) ? 4'h1 : 4'h0;
      tick(1);
      check_eq("t2_pb", 32'(pb_clean), 32'h0);
      check_eq("t2_press", 32'(pb_press), 32'h0);
      check_eq("t2_valid", 32'(operand_valid), 32'h0);
    end

    // 3: chatter on button 2, then a steady hold
    for (int c = 0; c < 4; c++) begin
      push_button = (c % 2 == 0) ? 4'h4 : 4'h0;
      tick(1);
    end
    push_button = 4'h4;
    tick(5);
    check_eq("t3_pb_early", 32'(pb_clean), 32'h0);
    tick(1);
    check_eq("t3_pb", 32'(pb_clean), 32'h4);
    check_eq("t3_press", 32'(pb_press), 32'h4);
    tick(1);
    check_eq("t3_press_gone", 32'(pb_press), 32'h0);
    check_eq("t3_opb", 32'(operand_b), 32'h4);
    check_eq("t3_valid", 32'(operand_valid), 32'h1);

    // 4: multi-bit switch change gives one strobe; upper nibble gives none
    toggle_switch = 8'h35;
    tick(5);
    check_eq("t4_sw_early", 32'(sw_clean), 32'h00);
    tick(1);
    check_eq("t4_sw", 32'(sw_clean), 32'h35);
    check_eq("t4_valid_early", 32'(operand_valid), 32'h0);
    tick(1);
    check_eq("t4_valid", 32'(operand_valid), 32'h1);
    check_eq("t4_opa", 32'(operand_a), 32'h5);
    check_eq("t4_opb", 32'(operand_b), 32'h4);
    tick(1);
    check_eq("t4_valid_once", 32'(operand_valid), 32'h0);
    toggle_switch = 8'h05;
    for (int c = 0; c < 8; c++) begin
      tick(1);
      check_eq("t4_hi_valid", 32'(operand_valid), 32'h0);
    end
    check_eq("t4_sw_hi", 32'(sw_clean), 32'h05);
    check_eq("t4_opa_hold", 32'(operand_a), 32'h5);

    // 5: press/release of button 1, then reset mid-count
    push_button = 4'h6;
    tick(6);
    check_eq("t5_pb", 32'(pb_clean), 32'h6);
    check_eq("t5_press", 32'(pb_press), 32'h2);
    tick(1);
    check_eq("t5_opb", 32'(operand_b), 32'h6);
    check_eq("t5_valid", 32'(operand_valid), 32'h1);
    push_button = 4'h4;
    tick(6);
    check_eq("t5_rel", 32'(pb_release), 32'h2);
    check_eq("t5_rel_press", 32'(pb_press), 32'h0);
    check_eq("t5_pb_rel", 32'(pb_clean), 32'h4);
    tick(1);
    check_eq("t5_rel_gone", 32'(pb_release), 32'h0);
    check_eq("t5_opb_rel", 32'(operand_b), 32'h4);
    check_eq("t5_valid_rel", 32'(operand_valid), 32'h1);
    push_button = 4'h5;
    tick(4);
    check_eq("t5_pb_midcount", 32'(pb_clean), 32'h4);
    reset         = 1'b1;
    toggle_switch = 8'h00;
    push_button   = 4'h0;
    #1;
    check_all_zero("t5_rst");
    tick(2);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      check_eq("t5_post_pb", 32'(pb_clean), 32'h0);
      check_eq("t5_post_press", 32'(pb_press), 32'h0);
      check_eq("t5_post_valid", 32'(operand_valid), 32'h0);
      check_eq("t5_post_sw", 32'(sw_clean), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
